// File: rtl/system_0_button_pio.sv
// Avalon-MM push-button input port: sync, debounce, falling-edge capture, irq.
// Define SYSTEM_0_BUTTON_DEBOUNCE_EN to build the per-bit debounce counters.
module system_0_button_pio #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] ec_clr;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             mask_we;
  logic             unused_bits;

  assign unused_bits = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync    <= '1;
    end else begin
      sync_q1 <= in_port;
      sync    <= sync_q1;
    end
  end

`ifdef SYSTEM_0_BUTTON_DEBOUNCE_EN
  logic [DEB_W-1:0] cnt [WIDTH];

  // A bit is accepted only after holding a new level for DEB_CYCLES clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (DEB_CYCLES > DEB_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '1;
    end else begin
      stable <= sync;
    end
  end
`endif

  assign fall    = stable_d & ~stable;
  assign wr      = chipselect & ~write_n;
  assign mask_we = wr && (address == 2'd2);
  assign ec_clr  = (wr && (address == 2'd3)) ?
                   writedata[WIDTH-1:0] : '0;

  // New press events take priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d     <= '1;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d     <= stable;
      edge_capture <= (edge_capture & ~ec_clr) | fall;
      irq          <= |(edge_capture & irq_mask);
      if (mask_we) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (address == 2'd0): rd_mux[WIDTH-1:0] = stable;
      (address == 2'd2): rd_mux[WIDTH-1:0] = irq_mask;
      (address == 2'd3): rd_mux[WIDTH-1:0] = edge_capture;
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
